// File: rtl/alu_pkg.sv
// Shared ALU operation encoding, common to the ALU control decoder and the execute unit.
package alu_pkg;

  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned ALU_WIDTH = 32;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;

  function automatic logic alu_op_legal(input alu_op_t op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Valid/ready request and response bundle of the ALU execute unit.
// The ovf signal exists only when ALU_OVF_EN is defined.
interface alu_exec_unit_if #(parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH);

  logic                in_valid;
  logic                in_ready;
  alu_pkg::alu_op_t    op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic                zero;
  logic                illegal;
`ifdef ALU_OVF_EN
  logic                ovf;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
`ifdef ALU_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal
`ifdef ALU_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: op/a/b to result, illegal flag and (with ALU_OVF_EN) signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  alu_op_t           i_op,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [WIDTH-1:0]  o_result,
  output logic              o_illegal
`ifdef ALU_OVF_EN
  , output logic            o_ovf
`endif
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_lt   = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result  = '0;
    o_illegal = !alu_op_legal(i_op);
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = w_sum;
      ALU_SUB: o_result = w_diff;
      ALU_SLT: o_result = WIDTH'(w_lt);
      default: o_result = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  // Overflow when operand signs allow it and the result sign disagrees with a.
  always_comb begin
    o_ovf = 1'b0;
    case (i_op)
      ALU_ADD: o_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
      ALU_SUB: o_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      default: o_ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage pipelined ALU execute unit with valid/ready on both sides.
// Define ALU_OVF_EN to add the registered signed-overflow output.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  logic             r_s1_v;
  alu_op_t          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             r_s2_v;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
`ifdef ALU_OVF_EN
  logic             w_ovf;
  logic             r_ovf;
`endif

  // S2 can take a new op when empty or when its current op leaves this cycle.
  assign w_s2_free  = !r_s2_v || bus.out_ready;
  assign w_s1_adv   = r_s1_v && w_s2_free;
  assign w_in_ready = !r_s1_v || w_s2_free;
  assign w_in_xfer  = bus.in_valid && w_in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_result  (w_result),
    .o_illegal (w_illegal)
`ifdef ALU_OVF_EN
    , .o_ovf   (w_ovf)
`endif
  );

  // Stage 1: operand capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_v <= 1'b0;
      r_op   <= ALU_AND;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_in_xfer) begin
      r_s1_v <= 1'b1;
      r_op   <= bus.op;
      r_a    <= bus.a;
      r_b    <= bus.b;
    end else if (w_s1_adv) begin
      r_s1_v <= 1'b0;
    end
  end

  // Stage 2: result registers; they only load on an advance, so a stalled output holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s2_v    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s2_v    <= 1'b1;
      r_result  <= w_result;
      r_zero    <= (w_result == '0);
      r_illegal <= w_illegal;
`ifdef ALU_OVF_EN
      r_ovf     <= w_ovf;
`endif
    end else if (bus.out_ready) begin
      r_s2_v    <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_v;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;
`ifdef ALU_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued on input transfer
// and compared on output transfer; ovf is checked when ALU_OVF_EN is defined.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
    logic         ovf;
    logic         lat;
    logic [31:0]  cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = '0;
  logic        lat_mode;
  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  alu_op_t     t_op[6] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, 4'b1111};
  logic [W-1:0] t_a[6] = '{32'd5, 32'd7, 32'h0000_F0F0, 32'h0000_F000, 32'hFFFF_FFFF, 32'd3};
  logic [W-1:0] t_b[6] = '{32'd7, 32'd7, 32'h0000_0FF0, 32'h0000_000F, 32'd1, 32'd4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: SLT by sign inspection, overflow by wide signed arithmetic.
  function automatic exp_t model(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint s;
    e = '0;
    case (op)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_ADD: begin
        e.res = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUB: begin
        e.res = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SLT: e.res = W'((a[W-1] != b[W-1]) ? a[W-1] : (a < b));
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // One clock: drive at negedge, observe settled state, book the transfers of the next posedge.
  task automatic cycle(input logic v, input alu_op_t o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic ordy, input logic rstv,
                       output logic acc);
    exp_t e;
    @(negedge clk);
    rst           = rstv;
    bus.in_valid  = v;
    bus.op        = o;
    bus.a         = aa;
    bus.b         = bb;
    bus.out_ready = ordy;
    #1;
    acc = v && (bus.in_ready === 1'b1) && rstv;
    if (!rstv) begin
      q.delete();
    end else begin
      if ((bus.out_valid === 1'b1) && ordy) begin
        chk("out_unexpected", 64'(q.size() == 0), 64'd0);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result",  64'(bus.result),  64'(e.res));
          chk("zero",    64'(bus.zero),    64'(e.zero));
          chk("illegal", 64'(bus.illegal), 64'(e.ill));
`ifdef ALU_OVF_EN
          chk("ovf",     64'(bus.ovf),     64'(e.ovf));
`endif
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (acc) begin
        e     = model(o, aa, bb);
        e.lat = lat_mode;
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      cycle(1'b0, ALU_AND, '0, '0, 1'b1, 1'b1, acc);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic    acc;
    int      idx;
    int      n;
    alu_op_t rop;
    alu_op_t bp_op[4] = '{ALU_ADD, ALU_OR, ALU_SUB, ALU_SLT};

    rst = 1'b0; lat_mode = 1'b0;
    bus.in_valid = 1'b0; bus.op = ALU_AND; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

    // Reset held for three edges with in_valid high.
    repeat (3) cycle(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b1, 1'b0, acc);
    cycle(1'b0, ALU_AND, '0, '0, 1'b1, 1'b1, acc);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd0);
    chk("rst_illegal",   64'(bus.illegal),   64'd0);
`ifdef ALU_OVF_EN
    chk("rst_ovf",       64'(bus.ovf),       64'd0);
`endif
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // Directed ops back to back, then random ops, all with out_ready high.
    lat_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, t_op[i], t_a[i], t_b[i], 1'b1, 1'b1, acc);
      chk("stream_accept", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: rop = ALU_AND;
        1: rop = ALU_OR;
        2: rop = ALU_ADD;
        3: rop = ALU_SUB;
        4: rop = ALU_SLT;
        default: rop = alu_op_t'($urandom_range(0, 15));
      endcase
      cycle(1'b1, rop, W'($urandom), W'($urandom), 1'b1, 1'b1, acc);
    end
    drain();

    // Overflow boundaries.
    cycle(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b1, acc);
    cycle(1'b1, ALU_SUB, 32'h8000_0000, 32'd1, 1'b1, 1'b1, acc);
    cycle(1'b1, ALU_SLT, 32'h8000_0000, 32'd1, 1'b1, 1'b1, acc);
    drain();

    // Backpressure: only two ops fit while out_ready is low.
    lat_mode = 1'b0;
    idx = 0;
    repeat (4) begin
      cycle(1'b1, bp_op[idx], W'(idx + 10), W'(idx + 1), 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, bp_op[idx], W'(idx + 10), W'(idx + 1), 1'b1, 1'b1, acc);
    chk("bp_no_bubble", 64'(acc), 64'd1);
    if (acc) idx++;
    n = 0;
    while (idx < 4 && n < 10) begin
      cycle(1'b1, bp_op[idx], W'(idx + 10), W'(idx + 1), 1'b1, 1'b1, acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_all_sent", 64'(idx), 64'd4);
    drain();

    // Reset with both stages full discards them.
    cycle(1'b1, ALU_ADD, 32'd100, 32'd1, 1'b0, 1'b1, acc);
    cycle(1'b1, ALU_SUB, 32'd200, 32'd1, 1'b0, 1'b1, acc);
    cycle(1'b0, ALU_AND, '0, '0, 1'b0, 1'b1, acc);
    chk("mid_full", 64'(bus.in_ready), 64'd0);
    cycle(1'b0, ALU_AND, '0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, ALU_AND, '0, '0, 1'b1, 1'b1, acc);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_result",    64'(bus.result),    64'd0);
    repeat (3) begin
      cycle(1'b0, ALU_AND, '0, '0, 1'b1, 1'b1, acc);
      chk("mid_rst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    lat_mode = 1'b1;
    cycle(1'b1, ALU_ADD, 32'd2, 32'd2, 1'b1, 1'b1, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
